// File: rtl/id_ex_stage_register_pkg.sv
// Shared decode/execute definitions: widths, control-bundle bit map, register r0 address,
// E-stage record and the write-back snoop match used by both operand paths.
package id_ex_stage_register_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 10;

  // Control bundle {RegWrite,MemtoReg,MemWrite,ALUCtl[3:0],ALUSrc,RegDst,Branch}
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMTOREG  = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_ALUCTL_HI = 6;
  localparam int CTRL_ALUCTL_LO = 3;
  localparam int CTRL_ALUSRC    = 2;
  localparam int CTRL_REGDST    = 1;
  localparam int CTRL_BRANCH    = 0;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } valid_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic [CTRL_W-1:0] ctrl;
  } e_stage_t;

  // r0 is hard-wired zero, so a write-back to it must never refresh an operand.
  function automatic logic snoop_hit(input logic              we,
                                     input logic [REG_AW-1:0] a3,
                                     input logic [REG_AW-1:0] addr);
    return we && (a3 != REG_ZERO) && (a3 == addr);
  endfunction

endpackage

// File: rtl/id_ex_stage_register_if.sv
// Decode->execute bus: D-stage fields, write-back snoop port and registered E-stage outputs.
interface id_ex_stage_register_if
  import id_ex_stage_register_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic              StallE;
  logic              FlushE;
  logic              ValidD;
  logic [DATA_W-1:0] RD1D;
  logic [DATA_W-1:0] RD2D;
  logic [REG_AW-1:0] RsD;
  logic [REG_AW-1:0] RtD;
  logic [REG_AW-1:0] RdD;
  logic [DATA_W-1:0] SignImmD;
  logic [DATA_W-1:0] PCPlus4D;
  logic [CTRL_W-1:0] CtrlD;
  logic              RegWriteW;
  logic [REG_AW-1:0] A3W;
  logic [DATA_W-1:0] WD3W;

  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [REG_AW-1:0] RsE;
  logic [REG_AW-1:0] RtE;
  logic [REG_AW-1:0] RdE;
  logic [DATA_W-1:0] SignImmE;
  logic [DATA_W-1:0] PCPlus4E;
  logic [CTRL_W-1:0] CtrlE;
  logic              ValidE;
  logic [REG_AW-1:0] WriteRegE;
  logic [CNT_W-1:0]  BubbleCnt;

  modport master (
    output StallE, FlushE, ValidD, RD1D, RD2D, RsD, RtD, RdD, SignImmD, PCPlus4D, CtrlD,
           RegWriteW, A3W, WD3W,
    input  RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCPlus4E, CtrlE, ValidE, WriteRegE, BubbleCnt
  );

  modport slave (
    input  StallE, FlushE, ValidD, RD1D, RD2D, RsD, RtD, RdD, SignImmD, PCPlus4D, CtrlD,
           RegWriteW, A3W, WD3W,
    output RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCPlus4E, CtrlE, ValidE, WriteRegE, BubbleCnt
  );

endinterface

// File: rtl/id_ex_stage_register_operand_snoop_mux.sv
// One operand's next value: fresh D data on load, held E data on stall, or the write-back
// value when the register being captured/held is written this cycle.
module operand_snoop_mux
  import id_ex_stage_register_pkg::*;
(
  input  logic              load_i,
  input  logic [REG_AW-1:0] addr_d_i,
  input  logic [REG_AW-1:0] addr_e_i,
  input  logic              reg_write_w_i,
  input  logic [REG_AW-1:0] a3_w_i,
  input  logic [DATA_W-1:0] data_d_i,
  input  logic [DATA_W-1:0] data_e_i,
  input  logic [DATA_W-1:0] wd3_w_i,
  output logic [DATA_W-1:0] data_o
);

  logic [REG_AW-1:0] addr;

  assign addr = load_i ? addr_d_i : addr_e_i;

  always_comb begin
    if (snoop_hit(reg_write_w_i, a3_w_i, addr)) data_o = wd3_w_i;
    else if (load_i)                            data_o = data_d_i;
    else                                        data_o = data_e_i;
  end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register: load, hold with write-back refresh, or bubble on flush,
// plus a saturating count of bubbles inserted since reset.
module id_ex_stage_register
  import id_ex_stage_register_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  id_ex_stage_register_if.slave bus
);

  e_stage_t          stage_d, stage_q;
  valid_state_e      state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [DATA_W-1:0] rd1_next, rd2_next;

  operand_snoop_mux u_snoop_rd1 (
    .load_i       (!bus.StallE),
    .addr_d_i     (bus.RsD),
    .addr_e_i     (stage_q.rs),
    .reg_write_w_i(bus.RegWriteW),
    .a3_w_i       (bus.A3W),
    .data_d_i     (bus.RD1D),
    .data_e_i     (stage_q.rd1),
    .wd3_w_i      (bus.WD3W),
    .data_o       (rd1_next)
  );

  operand_snoop_mux u_snoop_rd2 (
    .load_i       (!bus.StallE),
    .addr_d_i     (bus.RtD),
    .addr_e_i     (stage_q.rt),
    .reg_write_w_i(bus.RegWriteW),
    .a3_w_i       (bus.A3W),
    .data_d_i     (bus.RD2D),
    .data_e_i     (stage_q.rd2),
    .wd3_w_i      (bus.WD3W),
    .data_o       (rd2_next)
  );

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through this block infers a latch.
    stage_d = stage_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.FlushE) begin
      stage_d = '0;
      state_d = EMPTY;
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.StallE) begin
      stage_d.rd1 = rd1_next;
      stage_d.rd2 = rd2_next;
    end else begin
      stage_d = '{rd1: rd1_next, rd2: rd2_next, rs: bus.RsD, rt: bus.RtD, rd: bus.RdD,
                  imm: bus.SignImmD, pc4: bus.PCPlus4D, ctrl: bus.CtrlD};
      state_d = bus.ValidD ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (rst) begin
      stage_q <= '0;
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.RD1E      = stage_q.rd1;
  assign bus.RD2E      = stage_q.rd2;
  assign bus.RsE       = stage_q.rs;
  assign bus.RtE       = stage_q.rt;
  assign bus.RdE       = stage_q.rd;
  assign bus.SignImmE  = stage_q.imm;
  assign bus.PCPlus4E  = stage_q.pc4;
  assign bus.CtrlE     = stage_q.ctrl;
  assign bus.ValidE    = (state_q == FULL);
  assign bus.WriteRegE = stage_q.ctrl[CTRL_REGDST] ? stage_q.rd : stage_q.rt;
  assign bus.BubbleCnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for the ID/EX register: directed vector table, async reset mid-stall, random
// traffic against a reference model, and bubble-counter saturation with a 4-bit counter.
module tb_id_ex_stage_register;
  import id_ex_stage_register_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_register_if #(.CNT_W(CNT_W)) bus ();

  id_ex_stage_register #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the E stage, updated from the rules once per clock.
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc4;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [9:0]  m_ctrl;
  logic        m_valid;
  int          m_cnt;

  typedef struct {
    logic        stall, flush, valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2;
    logic [9:0]  ctrl;
    logic        rw;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] e_rd1, e_rd2;
    logic [9:0]  e_ctrl;
    logic        e_valid;
    logic [4:0]  e_wreg;
    int          e_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic wb_hits(input logic [4:0] a);
    return bus.RegWriteW && (bus.A3W != 5'd0) && (bus.A3W == a);
  endfunction

  task automatic model_reset();
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc4 = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0; m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (bus.FlushE) begin
      m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc4 = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0; m_valid = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (bus.StallE) begin
      if (wb_hits(m_rs)) m_rd1 = bus.WD3W;
      if (wb_hits(m_rt)) m_rd2 = bus.WD3W;
    end else begin
      m_rd1   = wb_hits(bus.RsD) ? bus.WD3W : bus.RD1D;
      m_rd2   = wb_hits(bus.RtD) ? bus.WD3W : bus.RD2D;
      m_rs    = bus.RsD;
      m_rt    = bus.RtD;
      m_rd    = bus.RdD;
      m_imm   = bus.SignImmD;
      m_pc4   = bus.PCPlus4D;
      m_ctrl  = bus.CtrlD;
      m_valid = bus.ValidD;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".RD1E"},      64'(bus.RD1E),      64'(m_rd1));
    check({tag, ".RD2E"},      64'(bus.RD2E),      64'(m_rd2));
    check({tag, ".RsE"},       64'(bus.RsE),       64'(m_rs));
    check({tag, ".RtE"},       64'(bus.RtE),       64'(m_rt));
    check({tag, ".RdE"},       64'(bus.RdE),       64'(m_rd));
    check({tag, ".SignImmE"},  64'(bus.SignImmE),  64'(m_imm));
    check({tag, ".PCPlus4E"},  64'(bus.PCPlus4E),  64'(m_pc4));
    check({tag, ".CtrlE"},     64'(bus.CtrlE),     64'(m_ctrl));
    check({tag, ".ValidE"},    64'(bus.ValidE),    64'(m_valid));
    check({tag, ".WriteRegE"}, 64'(bus.WriteRegE), 64'(m_ctrl[1] ? m_rd : m_rt));
    check({tag, ".BubbleCnt"}, 64'(bus.BubbleCnt), 64'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input vec_t v);
    bus.StallE    = v.stall;
    bus.FlushE    = v.flush;
    bus.ValidD    = v.valid;
    bus.RsD       = v.rs;
    bus.RtD       = v.rt;
    bus.RdD       = v.rd;
    bus.RD1D      = v.rd1;
    bus.RD2D      = v.rd2;
    bus.CtrlD     = v.ctrl;
    bus.RegWriteW = v.rw;
    bus.A3W       = v.a3;
    bus.WD3W      = v.wd;
    bus.SignImmD  = $urandom;
    bus.PCPlus4D  = $urandom;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            stall flush valid rs     rt     rd     rd1           rd2           ctrl    rw    a3     wd               e_rd1          e_rd2          e_ctrl  e_v   e_wreg e_cnt
    vecs[0] = '{1'b0, 1'b0, 1'b1, 5'd5,  5'd6,  5'd7,  32'hA,        32'hB,        10'h3FF, 1'b0, 5'd0, 32'h0,         32'hA,         32'hB,         10'h3FF, 1'b1, 5'd7, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 5'd9,  5'd9,  5'd9,  32'h1234,     32'h1234,     10'h000, 1'b1, 5'd5, 32'hBEEF,      32'hBEEF,      32'hB,         10'h3FF, 1'b1, 5'd7, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        10'h000, 1'b1, 5'd6, 32'hCAFE,      32'hBEEF,      32'hCAFE,      10'h3FF, 1'b1, 5'd7, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd3,  5'd2,  32'h0,        32'h5,        10'h000, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0,         32'h5,         10'h000, 1'b1, 5'd3, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 5'd4,  5'd4,  5'd9,  32'h1,        32'h2,        10'h002, 1'b1, 5'd4, 32'h77,        32'h77,        32'h77,        10'h002, 1'b1, 5'd9, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 5'd1,  5'd2,  5'd3,  32'h3,        32'h4,        10'h000, 1'b0, 5'd0, 32'h0,         32'h3,         32'h4,         10'h000, 1'b0, 5'd2, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 5'd4,  5'd4,  5'd4,  32'h9,        32'h9,        10'h3FF, 1'b1, 5'd4, 32'h55,        32'h0,         32'h0,         10'h000, 1'b0, 5'd0, 1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 5'd5,  5'd5,  5'd5,  32'h9,        32'h9,        10'h3FF, 1'b0, 5'd0, 32'h0,         32'h0,         32'h0,         10'h000, 1'b0, 5'd0, 2};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 5'd1,  5'd1,  5'd1,  32'h9,        32'h9,        10'h3FF, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0,         32'h0,         10'h000, 1'b0, 5'd0, 2};

    drive('{default: '0});
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.RD1E", i),      64'(bus.RD1E),      64'(vecs[i].e_rd1));
      check($sformatf("vec%0d.RD2E", i),      64'(bus.RD2E),      64'(vecs[i].e_rd2));
      check($sformatf("vec%0d.CtrlE", i),     64'(bus.CtrlE),     64'(vecs[i].e_ctrl));
      check($sformatf("vec%0d.ValidE", i),    64'(bus.ValidE),    64'(vecs[i].e_valid));
      check($sformatf("vec%0d.WriteRegE", i), 64'(bus.WriteRegE), 64'(vecs[i].e_wreg));
      check($sformatf("vec%0d.BubbleCnt", i), 64'(bus.BubbleCnt), 64'(vecs[i].e_cnt));
    end

    // Async reset asserted between edges while stalled must clear outputs immediately.
    drive('{stall: 1'b0, flush: 1'b0, valid: 1'b1, rs: 5'd3, rt: 5'd4, rd: 5'd5,
            rd1: 32'h1234, rd2: 32'h55, ctrl: 10'h3FF, default: '0});
    cycle("pre_rst");
    check("pre_rst.RD1E", 64'(bus.RD1E), 64'h1234);
    bus.StallE = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("mid_rst");
    check("mid_rst.RD1E_zero", 64'(bus.RD1E), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model("rst_held");
    bus.StallE = 1'b0;
    cycle("post_rst");

    for (int i = 0; i < 300; i++) begin
      bus.StallE    = ($urandom_range(3) == 0);
      bus.FlushE    = ($urandom_range(7) == 0);
      bus.ValidD    = 1'($urandom);
      bus.RsD       = 5'($urandom_range(3));
      bus.RtD       = 5'($urandom_range(3));
      bus.RdD       = 5'($urandom);
      bus.RD1D      = $urandom;
      bus.RD2D      = $urandom;
      bus.SignImmD  = $urandom;
      bus.PCPlus4D  = $urandom;
      bus.CtrlD     = 10'($urandom);
      bus.RegWriteW = 1'($urandom);
      bus.A3W       = 5'($urandom_range(3));
      bus.WD3W      = $urandom;
      cycle($sformatf("rnd%0d", i));
    end

    // Counter saturation: reach all-ones-1, then three more flushes must not wrap.
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive('{flush: 1'b1, default: '0});
    repeat (CNT_MAX - 1) cycle("sat_fill");
    check("sat.pre", 64'(bus.BubbleCnt), 64'(CNT_MAX - 1));
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("sat%0d", i));
      check($sformatf("sat%0d.BubbleCnt", i), 64'(bus.BubbleCnt), 64'(CNT_MAX));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
